// File: rtl/mem_stage.sv
// Memory-access pipeline stage: aligns, extends and merges load data from the
// synchronous data SRAM, or passes the ALU result through, toward write-back.
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 106
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif

module mem_stage (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        ms_allowin,
    input  logic                        es_to_ms_valid,
    input  logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                        ws_allowin,
    output logic                        ms_to_ws_valid,
    output logic [`MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                 data_sram_rdata,
    output logic [5:0]                  reg_code_MS,
    output logic [37:0]                 ms_fwd_bus
);

    // Handshake: a transfer happens on an edge where the producer's valid and the
    // consumer's allowin are both high; valid never depends on the consumer's allowin.
    logic                        ms_valid;
    logic                        ms_ready_go;
    logic [`ES_TO_MS_BUS_WD-1:0] bus_r;
    logic                        hold_vld;
    logic [31:0]                 hold_buf;

    logic [2:0]  load_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rt_value;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [1:0]  addr_lo;
    logic [31:0] mem_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign {load_op, res_from_mem, gr_we, dest, rt_value, alu_result, pc} = bus_r;
    assign addr_lo = alu_result[1:0];

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            bus_r    <= '0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid) begin
                bus_r <= es_to_ms_bus;
            end
        end
    end

    // SRAM data is only valid in the first stage cycle; capture it if write-back stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vld <= 1'b0;
            hold_buf <= '0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            hold_vld <= 1'b0;
        end else if (ms_valid && !hold_vld && !ws_allowin) begin
            hold_vld <= 1'b1;
            hold_buf <= data_sram_rdata;
        end
    end

    assign mem_data = hold_vld ? hold_buf : data_sram_rdata;

    always_comb begin
        byte_sel    = 8'h00;
        half_sel    = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
        load_result = mem_data;
        case (addr_lo)
            2'd0: byte_sel = mem_data[7:0];
            2'd1: byte_sel = mem_data[15:8];
            2'd2: byte_sel = mem_data[23:16];
            default: byte_sel = mem_data[31:24];
        endcase
        case (load_op)
            3'b001: load_result = {{24{byte_sel[7]}}, byte_sel};
            3'b010: load_result = {24'h0, byte_sel};
            3'b011: load_result = {{16{half_sel[15]}}, half_sel};
            3'b100: load_result = {16'h0, half_sel};
            3'b101: begin
                case (addr_lo)
                    2'd0: load_result = {mem_data[7:0], rt_value[23:0]};
                    2'd1: load_result = {mem_data[15:0], rt_value[15:0]};
                    2'd2: load_result = {mem_data[23:0], rt_value[7:0]};
                    default: load_result = mem_data;
                endcase
            end
            3'b110: begin
                case (addr_lo)
                    2'd0: load_result = mem_data;
                    2'd1: load_result = {rt_value[31:24], mem_data[31:8]};
                    2'd2: load_result = {rt_value[31:16], mem_data[31:16]};
                    default: load_result = {rt_value[31:8], mem_data[31:24]};
                endcase
            end
            default: load_result = mem_data;
        endcase
    end

    assign final_result = res_from_mem ? load_result : alu_result;

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign reg_code_MS  = {ms_valid && gr_we, dest};
    assign ms_fwd_bus   = {ms_valid && gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/stall/reset cases plus random
// instructions scored against an arithmetic reference model and an expected queue.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [105:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [69:0]  ms_to_ws_bus;
    logic [31:0]  data_sram_rdata;
    logic [5:0]   reg_code_MS;
    logic [37:0]  ms_fwd_bus;

    int n_assert = 0;
    int n_fail   = 0;
    logic [69:0] exp_q[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk),
        .reset(reset),
        .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid),
        .es_to_ms_bus(es_to_ms_bus),
        .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid),
        .ms_to_ws_bus(ms_to_ws_bus),
        .data_sram_rdata(data_sram_rdata),
        .reg_code_MS(reg_code_MS),
        .ms_fwd_bus(ms_fwd_bus)
    );

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: shifts and masks over the whole word rather than per-case slicing.
    function automatic logic [31:0] model(input logic [2:0] op, input logic rfm,
                                          input logic [31:0] alu, input logic [31:0] rt,
                                          input logic [31:0] mem);
        int unsigned a;
        int unsigned sh;
        logic [31:0] b;
        logic [31:0] h;
        logic [63:0] mask;
        a = alu[1:0];
        b = (mem >> (8 * a)) & 32'hFF;
        h = (mem >> (16 * (a / 2))) & 32'hFFFF;
        if (!rfm) return alu;
        case (op)
            3'd1: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd2: return b;
            3'd3: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd4: return h;
            3'd5: begin
                sh   = 8 * (3 - a);
                mask = (64'd1 << sh) - 64'd1;
                return (mem << sh) | (rt & mask[31:0]);
            end
            3'd6: begin
                sh = 8 * a;
                return (mem >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
            end
            default: return mem;
        endcase
    endfunction

    // Present one instruction, let it be accepted, supply its SRAM data, check it.
    task automatic issue(input logic [2:0] op, input logic rfm, input logic we,
                         input logic [4:0] dst, input logic [31:0] rt, input logic [31:0] alu,
                         input logic [31:0] pcv, input logic [31:0] mem,
                         input logic [31:0] exp_res, input string tag);
        logic [69:0] exp_bus;
        exp_bus = {we, dst, exp_res, pcv};
        es_to_ms_bus   = {op, rfm, we, dst, rt, alu, pcv};
        es_to_ms_valid = 1'b1;
        exp_q.push_back(exp_bus);
        @(posedge clk);
        #1;
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = mem;
        #1;
        chk({tag, "_valid"}, 70'(ms_to_ws_valid), 70'd1);
        chk({tag, "_bus"}, ms_to_ws_bus, exp_bus);
        chk({tag, "_fwd"}, 70'(ms_fwd_bus), 70'({we, dst, exp_res}));
        chk({tag, "_regcode"}, 70'(reg_code_MS), 70'({we, dst}));
    endtask

    // Scoreboard: every write-back handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_handshake", 70'd1, 70'd0);
            end else begin
                chk("sb_handshake", ms_to_ws_bus, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  op;
        logic        rfm;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] mem;
        reset           = 1'b1;
        es_to_ms_valid  = 1'b1;
        es_to_ms_bus    = {3'd0, 1'b0, 1'b1, 5'd5, 32'h0, 32'h12345678, 32'hBFC00010};
        ws_allowin      = 1'b1;
        data_sram_rdata = 32'h0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_valid", 70'(ms_to_ws_valid), 70'd0);
            chk("rst_allowin", 70'(ms_allowin), 70'd1);
            chk("rst_regcode", 70'(reg_code_MS), 70'd0);
            chk("rst_fwd", 70'(ms_fwd_bus), 70'd0);
        end
        reset = 1'b0;

        issue(3'd0, 1'b0, 1'b1, 5'd5, 32'h0, 32'h12345678, 32'hBFC00010, 32'hCAFEF00D,
              32'h12345678, "pass");

        issue(3'd1, 1'b1, 1'b1, 5'd1, 32'h0, 32'h00001003, 32'h100, 32'h80FF7F01, 32'hFFFFFF80, "lb_a3");
        issue(3'd2, 1'b1, 1'b1, 5'd2, 32'h0, 32'h00001003, 32'h104, 32'h80FF7F01, 32'h00000080, "lbu_a3");
        issue(3'd3, 1'b1, 1'b1, 5'd3, 32'h0, 32'h00001002, 32'h108, 32'h80FF7F01, 32'hFFFF80FF, "lh_a2");
        issue(3'd4, 1'b1, 1'b1, 5'd4, 32'h0, 32'h00001000, 32'h10C, 32'h80FF7F01, 32'h00007F01, "lhu_a0");
        issue(3'd5, 1'b1, 1'b1, 5'd6, 32'hAABBCCDD, 32'h2001, 32'h110, 32'h11223344, 32'h3344CCDD, "lwl_a1");
        issue(3'd6, 1'b1, 1'b1, 5'd7, 32'hAABBCCDD, 32'h2002, 32'h114, 32'h11223344, 32'hAABB1122, "lwr_a2");
        issue(3'd5, 1'b1, 1'b1, 5'd8, 32'hAABBCCDD, 32'h2003, 32'h118, 32'h11223344, 32'h11223344, "lwl_a3");
        issue(3'd6, 1'b1, 1'b0, 5'd9, 32'hAABBCCDD, 32'h2000, 32'h11C, 32'h11223344, 32'h11223344, "lwr_a0");
        issue(3'd7, 1'b1, 1'b1, 5'd10, 32'h0, 32'h2002, 32'h120, 32'h5A5A0F0F, 32'h5A5A0F0F, "op7_lw");

        // Stall: the held word must survive SRAM data changing underneath it.
        issue(3'd0, 1'b1, 1'b1, 5'd11, 32'h0, 32'h3000, 32'h200, 32'hDEADBEEF, 32'hDEADBEEF, "stall_lw");
        ws_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            data_sram_rdata = (i % 2 == 0) ? 32'h0 : $urandom;
            #1;
            chk("stall_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEADBEEF));
            chk("stall_allowin", 70'(ms_allowin), 70'd0);
            chk("stall_valid", 70'(ms_to_ws_valid), 70'd1);
        end
        ws_allowin = 1'b1;
        #1;
        chk("release_allowin", 70'(ms_allowin), 70'd1);
        // Handshake, new accept and hold clear on one edge: new load must see fresh data.
        issue(3'd0, 1'b1, 1'b1, 5'd12, 32'h0, 32'h3004, 32'h204, 32'h01234567, 32'h01234567, "post_stall");

        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(7, 0));
            rfm = 1'($urandom_range(1, 0));
            alu = $urandom;
            rt  = $urandom;
            mem = $urandom;
            issue(op, rfm, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), rt, alu,
                  $urandom, mem, model(op, rfm, alu, rt, mem), "rand");
        end

        // Back-to-back trio, then stall the last one and reset it away.
        issue(3'd0, 1'b0, 1'b1, 5'd13, 32'h0, 32'hA0000001, 32'h300, $urandom, 32'hA0000001, "b2b_0");
        issue(3'd2, 1'b1, 1'b1, 5'd14, 32'h0, 32'h00000001, 32'h304, 32'h0000C300, 32'h000000C3, "b2b_1");
        issue(3'd1, 1'b1, 1'b1, 5'd15, 32'h0, 32'h00000002, 32'h308, 32'h00F10000, 32'hFFFFFFF1, "b2b_2");
        ws_allowin = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ws_allowin = 1'b1;
        void'(exp_q.pop_back());
        chk("rst_mid_stall_valid", 70'(ms_to_ws_valid), 70'd0);
        chk("rst_mid_stall_regcode", 70'(reg_code_MS), 70'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_stall_idle", 70'(ms_to_ws_valid), 70'd0);
        chk("sb_drained", 70'(exp_q.size()), 70'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
